regs_dump: RTL and testbench
============================

Name: regs_dump

Overview:
- Debugger-side reader for the register heap's third (debug) read port.
- On a command it walks one register or all registers. It drives the debug read address and captures the returned value.
- Each captured value is serialised into a framed byte stream with a valid/ready handshake, for the debug UART/link.
- Sits between the debug command decoder and the register heap's debug port. It never writes registers.

Parameters:
- HEADER, 8'hA5, first byte of every frame.
- NUM_REGS, 32, number of registers walked by a dump-all command (1..32, indices 0..NUM_REGS-1).

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- cmd_valid  input  1  command present
- cmd_ready  output  1  block accepts command (IDLE only)
- cmd_all  input  1  1 = dump registers 0..NUM_REGS-1; 0 = single register cmd_addr
- cmd_addr  input  5  register index for single read
- dbg_addr  output  5  to register heap debug read address
- dbg_val  input  32  from register heap debug read value (combinational, write-bypassed, reg0 reads 0)
- tx_data  output  8  stream byte
- tx_valid  output  1  stream byte valid
- tx_ready  input  1  sink accepts byte
- busy  output  1  frame in progress

Behaviour:
- Reset values: cmd_ready=0 during reset, then 1 in IDLE. dbg_addr=0, tx_data=0, tx_valid=0, busy=0. State=IDLE, counters=0, checksum=0.
- Clock and reset: clock clk; reset rst_n, asynchronous, active-low.
- Frame format:
  - HEADER
  - then per register: address byte {3'b000, idx}, then 4 data bytes LSB first
  - then checksum byte = XOR of all bytes after HEADER, up to and including the last data byte.
- Frame length: 7 bytes single; 2+5*NUM_REGS bytes dump-all (162 at default).
- States:
  - IDLE: cmd_ready=1. A command is accepted on cmd_valid&&cmd_ready. That edge latches mode, sets idx = cmd_all ? 0 : cmd_addr, loads tx_data=HEADER, sets tx_valid=1, busy=1, and goes to HDR.
  - HDR: on handshake -> ADDR, with tx_data={3'b0,idx}.
  - ADDR: on handshake, capture dbg_val into a 32-bit shift register at that same edge and fold the address byte into the checksum. Present byte0 -> DATA, byte counter=0.
  - DATA: on each handshake, fold the byte into the checksum and shift. After byte 3:
    - if single mode or idx==NUM_REGS-1 -> CSUM;
    - else idx+1 -> ADDR.
  - CSUM: present the accumulated checksum. On handshake -> IDLE, tx_valid=0, busy=0, checksum cleared.
- Latency: tx_valid rises the cycle after command acceptance. No bubbles: the next byte is presented in the cycle after each handshake.
- Handshake: a transfer occurs when tx_valid&&tx_ready at a rising edge. While tx_valid=1 and tx_ready=0, tx_data is held stable and tx_valid stays high indefinitely. tx_valid never drops mid-frame.
- dbg_addr is always driven with the current idx (registered) and is stable through ADDR.
- Value is sampled only at the ADDR handshake edge. A same-cycle register write to that index is captured via the heap's bypass. Later writes do not alter bytes already captured.
- cmd_valid outside IDLE is ignored (cmd_ready=0). No command queueing.
- Single mode with cmd_addr >= NUM_REGS is still honoured (5-bit index, reads whatever the heap returns).
- Reset mid-frame: frame aborted immediately, all outputs return to reset values, no resumption, partial frame is not completed.

Decomposition:
- Shared debug package: HEADER default, frame-state encoding (IDLE, HDR, ADDR, DATA, CSUM), frame-length constants.
- One natural sub-module: regs_dump_ser, a 32-bit to 4-byte LSB-first shift/hold stage with running XOR. The FSM and idx counter stay in regs_dump.

Test Plan:
- Single read: reg5=0x12345678, cmd_all=0, cmd_addr=5, tx_ready=1 -> stream A5 05 78 56 34 12 0D. busy high for exactly 7 handshakes. tx_valid rises 1 cycle after acceptance.
- Reg0: cmd_addr=0 -> A5 00 00 00 00 00 00.
- Dump-all: all regs 0 except reg31=0xFFFFFFFF -> 162 bytes. Byte 157 = 0x1F, bytes 158-161 = FF, checksum byte = 0x00. Addr bytes increment 00..1F.
- Backpressure: tx_ready low for 10 cycles while presenting data byte 2 of reg5 -> tx_data=0x34 and tx_valid=1 held stable, no byte lost or duplicated. A second cmd_valid pulse during the frame is ignored.
- Bypass capture: regfile write reg5=0xCAFEBABE in the same cycle as the ADDR handshake for reg5 (old value 0x11111111) -> data bytes BE BA FE CA.
- Reset mid-frame: assert rst_n=0 during DATA of reg10 in a dump-all -> tx_valid=0, busy=0, dbg_addr=0 asynchronously. After release, a new single command for reg3 produces a clean 7-byte frame.

Source files
------------

// File: rtl/regs_dump_pkg.sv
// Shared definitions for the debug register dump path: frame header,
// frame-state encoding and frame-length helpers.
package regs_dump_pkg;

    localparam logic [7:0] HEADER_DEF       = 8'hA5;
    localparam int         NUM_REGS_DEF     = 32;
    localparam int         BYTES_PER_REG    = 5;
    localparam int         SINGLE_FRAME_LEN = 2 + BYTES_PER_REG;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_ADDR,
        ST_DATA,
        ST_CSUM
    } frame_state_t;

    function automatic int frame_len(input int n_regs);
        return 2 + BYTES_PER_REG * n_regs;
    endfunction

endpackage

// File: rtl/regs_dump_if.sv
// Command, register-heap debug port and byte-stream signals of the dump block.
interface regs_dump_if;
    import regs_dump_pkg::*;

    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_all;
    logic [4:0]  cmd_addr;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_val;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;

    modport master (
        output cmd_valid, cmd_all, cmd_addr, dbg_val, tx_ready,
        input  cmd_ready, dbg_addr, tx_data, tx_valid, busy
    );

    modport slave (
        input  cmd_valid, cmd_all, cmd_addr, dbg_val, tx_ready,
        output cmd_ready, dbg_addr, tx_data, tx_valid, busy
    );

endinterface

// File: rtl/regs_dump_ser.sv
// 32-bit capture register shifted out LSB first, with the running XOR
// checksum of every byte sent after the header.
module regs_dump_ser
    import regs_dump_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic [7:0]  i_addr_byte,
    input  logic [31:0] i_val,
    input  logic        i_shift,
    input  logic        i_clear,
    output logic [7:0]  o_next_byte,
    output logic [7:0]  o_csum_next
);

    logic [31:0] r_sh;
    logic [7:0]  r_csum;

    // r_sh[7:0] is always the byte currently on the stream while in DATA
    assign o_next_byte = r_sh[15:8];
    assign o_csum_next = r_csum ^ r_sh[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh   <= '0;
            r_csum <= '0;
        end else if (i_clear) begin
            r_csum <= '0;
        end else if (i_load) begin
            r_sh   <= i_val;
            r_csum <= r_csum ^ i_addr_byte;
        end else if (i_shift) begin
            r_sh   <= {8'h00, r_sh[31:8]};
            r_csum <= r_csum ^ r_sh[7:0];
        end
    end

endmodule

// File: rtl/regs_dump.sv
// Debug-port register reader: walks one or all registers and emits each
// value as a framed, checksummed byte stream.
module regs_dump
    import regs_dump_pkg::*;
#(
    parameter logic [7:0] HEADER   = HEADER_DEF,
    parameter int         NUM_REGS = NUM_REGS_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    regs_dump_if.slave bus
);

    localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

    frame_state_t r_state;
    logic [4:0]   r_idx;
    logic         r_all;
    logic [1:0]   r_cnt;
    logic [7:0]   r_tx_data;
    logic         r_tx_valid;
    logic         r_busy;
    logic         r_cmd_ready;

    logic       w_hs;
    logic       w_load;
    logic       w_shift;
    logic       w_clear;
    logic [7:0] w_next_byte;
    logic [7:0] w_csum_next;
    logic [4:0] w_idx_inc;

    assign w_hs      = r_tx_valid && bus.tx_ready;
    assign w_load    = w_hs && (r_state == ST_ADDR);
    assign w_shift   = w_hs && (r_state == ST_DATA);
    assign w_clear   = w_hs && (r_state == ST_CSUM);
    assign w_idx_inc = r_idx + 5'd1;

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.dbg_addr  = r_idx;
    assign bus.tx_data   = r_tx_data;
    assign bus.tx_valid  = r_tx_valid;
    assign bus.busy      = r_busy;

    // During ADDR the address byte is on tx_data, so it doubles as the checksum input
    regs_dump_ser u_ser (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_load),
        .i_addr_byte (r_tx_data),
        .i_val       (bus.dbg_val),
        .i_shift     (w_shift),
        .i_clear     (w_clear),
        .o_next_byte (w_next_byte),
        .o_csum_next (w_csum_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_all       <= 1'b0;
            r_cnt       <= '0;
            r_tx_data   <= '0;
            r_tx_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_cmd_ready <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.cmd_valid && r_cmd_ready) begin
                        r_all       <= bus.cmd_all;
                        r_idx       <= bus.cmd_all ? 5'd0 : bus.cmd_addr;
                        r_tx_data   <= HEADER;
                        r_tx_valid  <= 1'b1;
                        r_busy      <= 1'b1;
                        r_cmd_ready <= 1'b0;
                        r_state     <= ST_HDR;
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                ST_HDR: begin
                    if (w_hs) begin
                        r_tx_data <= {3'b000, r_idx};
                        r_state   <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (w_hs) begin
                        r_tx_data <= bus.dbg_val[7:0];
                        r_cnt     <= '0;
                        r_state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_hs) begin
                        if (r_cnt == 2'd3) begin
                            if (!r_all || r_idx == LAST_IDX) begin
                                r_tx_data <= w_csum_next;
                                r_state   <= ST_CSUM;
                            end else begin
                                r_idx     <= w_idx_inc;
                                r_tx_data <= {3'b000, w_idx_inc};
                                r_state   <= ST_ADDR;
                            end
                        end else begin
                            r_cnt     <= r_cnt + 2'd1;
                            r_tx_data <= w_next_byte;
                        end
                    end
                end
                ST_CSUM: begin
                    if (w_hs) begin
                        r_tx_data   <= '0;
                        r_tx_valid  <= 1'b0;
                        r_busy      <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_tx_valid  <= 1'b0;
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regs_dump.sv
// Directed bench for regs_dump with a small register-heap model on the debug port.
module tb_regs_dump;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    regs_dump_if u_if ();

    regs_dump u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    always #5 clk = ~clk;

    // Register heap model: write port plus bypassed, reg0-is-zero debug read
    logic [31:0] regs [32];
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;

    always @(posedge clk) if (wr_en) regs[wr_addr] <= wr_data;

    always_comb begin
        u_if.dbg_val = 32'h0;
        if (u_if.dbg_addr != 5'd0)
            u_if.dbg_val = (wr_en && wr_addr == u_if.dbg_addr) ? wr_data : regs[u_if.dbg_addr];
    end

    int total = 0;
    int passed = 0;
    logic [7:0] fb [0:199];
    int fn, cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wreg(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic send_cmd(input logic all, input logic [4:0] addr);
        @(negedge clk);
        chk("pre_tx_valid", u_if.tx_valid, 1'b0);
        u_if.cmd_valid = 1'b1; u_if.cmd_all = all; u_if.cmd_addr = addr;
        @(negedge clk);
        u_if.cmd_valid = 1'b0;
        chk("acc_tx_valid", u_if.tx_valid, 1'b1);
        chk("acc_busy", u_if.busy, 1'b1);
        chk("acc_header", u_if.tx_data, 8'hA5);
    endtask

    // Collects stream bytes; optional stall, same-cycle heap write, or reset at a byte index
    task automatic collect(input int maxc, input int stall_at, input int wr_at, input int rst_at);
        bit done = 0;
        bit stalled = 0;
        int bad;
        fn = 0; cyc = 0;
        while (!done && cyc < maxc) begin
            wr_en = (fn == wr_at) && u_if.tx_valid;
            if (fn == rst_at && u_if.tx_valid) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rst_tx_valid", u_if.tx_valid, 1'b0);
                chk("rst_busy", u_if.busy, 1'b0);
                chk("rst_dbg_addr", u_if.dbg_addr, 5'd0);
                chk("rst_tx_data", u_if.tx_data, 8'h00);
                done = 1;
                break;
            end
            if (fn == stall_at && u_if.tx_valid && !stalled) begin
                stalled = 1;
                bad = 0;
                u_if.tx_ready = 1'b0;
                for (int j = 0; j < 10; j++) begin
                    @(negedge clk);
                    u_if.cmd_valid = (j == 3);
                    u_if.cmd_all = 1'b1;
                    if (u_if.tx_data !== 8'h34 || u_if.tx_valid !== 1'b1) bad++;
                end
                u_if.cmd_valid = 1'b0;
                chk("bp_hold_stable", bad, 0);
                chk("bp_cmd_ready", u_if.cmd_ready, 1'b0);
                u_if.tx_ready = 1'b1;
            end
            if (u_if.tx_valid && u_if.tx_ready) begin
                fb[fn] = u_if.tx_data;
                fn++;
            end
            @(negedge clk);
            cyc++;
            if (!u_if.busy) done = 1;
        end
        wr_en = 1'b0;
        chk("collect_bounded", done, 1'b1);
    endtask

    task automatic chk_single(input string tag, input logic [55:0] exp);
        for (int i = 0; i < 7; i++)
            chk($sformatf("%s_b%0d", tag, i), fb[i], exp[55 - 8*i -: 8]);
        chk({tag, "_len"}, fn, 7);
        chk({tag, "_cycles"}, cyc, 7);
        chk({tag, "_idle_ready"}, u_if.cmd_ready, 1'b1);
    endtask

    initial begin
        int bad_addr, bad_data;
        u_if.cmd_valid = 1'b0; u_if.cmd_all = 1'b0; u_if.cmd_addr = '0;
        u_if.tx_ready = 1'b1;

        // Reset values while rst_n is low
        #12;
        chk("rst0_cmd_ready", u_if.cmd_ready, 1'b0);
        chk("rst0_tx_valid", u_if.tx_valid, 1'b0);
        chk("rst0_busy", u_if.busy, 1'b0);
        chk("rst0_dbg_addr", u_if.dbg_addr, 5'd0);
        chk("rst0_tx_data", u_if.tx_data, 8'h00);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("idle_cmd_ready", u_if.cmd_ready, 1'b1);

        // Single read of reg5
        wreg(5'd5, 32'h12345678);
        send_cmd(1'b0, 5'd5);
        collect(50, -1, -1, -1);
        chk_single("single5", 56'hA5_05_78_56_34_12_0D);

        // Reg0 always reads zero
        send_cmd(1'b0, 5'd0);
        collect(50, -1, -1, -1);
        chk_single("single0", 56'hA5_00_00_00_00_00_00);

        // Backpressure on data byte 2 of reg5, with a stray command mid-frame
        send_cmd(1'b0, 5'd5);
        collect(50, 4, -1, -1);
        chk_single("bp5", 56'hA5_05_78_56_34_12_0D);
        repeat (3) @(negedge clk);
        chk("bp_no_queued_cmd", u_if.busy, 1'b0);

        // Write landing on the same edge as the ADDR handshake is captured
        wreg(5'd5, 32'h11111111);
        wr_addr = 5'd5; wr_data = 32'hCAFEBABE;
        send_cmd(1'b0, 5'd5);
        collect(50, -1, 1, -1);
        chk_single("bypass5", 56'hA5_05_BE_BA_FE_CA_35);

        // Dump-all: only reg31 non-zero
        for (int r = 1; r < 31; r++) wreg(5'(r), 32'h0);
        wreg(5'd31, 32'hFFFFFFFF);
        send_cmd(1'b1, 5'd7);
        collect(400, -1, -1, -1);
        chk("all_len", fn, 162);
        chk("all_cycles", cyc, 162);
        bad_addr = 0; bad_data = 0;
        for (int k = 0; k < 32; k++) begin
            if (fb[1 + 5*k] !== 8'(k)) bad_addr++;
            for (int b = 0; b < 4; b++)
                if (fb[2 + 5*k + b] !== ((k == 31) ? 8'hFF : 8'h00)) bad_data++;
        end
        chk("all_header", fb[0], 8'hA5);
        chk("all_addr_seq", bad_addr, 0);
        chk("all_data", bad_data, 0);
        chk("all_last_addr", fb[156], 8'h1F);
        chk("all_last_data", {fb[157], fb[158], fb[159], fb[160]}, 32'hFFFFFFFF);
        chk("all_csum", fb[161], 8'h00);

        // Reset in the middle of reg10's data bytes, then a clean frame
        send_cmd(1'b1, 5'd0);
        collect(400, -1, -1, 53);
        chk("abort_addr10", fb[51], 8'h0A);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("post_rst_ready", u_if.cmd_ready, 1'b1);
        wreg(5'd3, 32'hA1B2C3D4);
        send_cmd(1'b0, 5'd3);
        collect(50, -1, -1, -1);
        chk_single("single3", 56'hA5_03_D4_C3_B2_A1_07);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
